alu_ctrl_stage: RTL and testbench
=================================

Name: alu_ctrl_stage

Overview:
- ID-side producer of the ALU control interface for the pipelined MIPS core.
- Decodes the ID-stage instruction into ALUFun/Sign plus operand-select and destination fields, and holds them in the ID/EX pipeline register.
- Honours hazard-unit stall and branch/jump flush.
- The EX-stage ALU consumes its registered outputs directly.

Parameters:
- NOP_FUN, 6'b000000, ALUFun value driven for bubbles and illegal opcodes (ADD).
- LUI_SHAMT, 16, shift amount emitted for lui.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous active-low reset.
- id_instr  in  32  instruction in IF/ID.
- id_valid  in  1  IF/ID holds a real instruction.
- stall  in  1  hold ID/EX contents (load-use hazard).
- flush  in  1  replace the next ID/EX contents with a bubble.
- ex_valid  out  1  ID/EX holds a real instruction.
- ex_ALUFun  out  6  ALU function code.
- ex_Sign  out  1  signed compare for LT.
- ex_ALUSrcA  out  1  0 = rs data, 1 = zero-extended ex_shamt.
- ex_ALUSrcB  out  1  0 = rt data, 1 = extended immediate.
- ex_ExtOp  out  1  1 = sign-extend imm16, 0 = zero-extend.
- ex_shamt  out  5  shift amount.
- ex_imm  out  16  instr[15:0].
- ex_rs, ex_rt  out  5 each  source register indices (for forwarding).
- ex_wr  out  5  destination register; 0 if none.
- ex_RegWrite  out  1  write-back enable.
- ex_illegal  out  1  undecodable instruction.

Behaviour:
- Reset (reset=0, asynchronous) clears every output to 0; ex_ALUFun resets to NOP_FUN.
- Latency: decode is combinational from id_instr; outputs update on the clk edge after id_instr is presented (1 cycle).
- Priority per edge: flush > stall > load.
  - flush=1: load a bubble. Bubble = ex_valid 0, ex_RegWrite 0, ex_wr 0, ex_ALUFun NOP_FUN, all other outputs 0. Applies even if stall=1 in the same cycle.
  - stall=1, flush=0: all outputs hold.
  - Otherwise: load the decoded instruction, with ex_valid = id_valid.
- id_valid=0 with no stall/flush: load a bubble.
- ALUFun codes: ADD 000000, SUB 000001, AND 011000, OR 011110, XOR 010110, NOR 010001, A 011010, SLL 100000, SRL 100001, SRA 100011, EQ 110011, NEQ 110001, LT 110101, LEZ 111101, LTZ 111011, GTZ 111111.
- R-type (op 0x00), decoded on funct; ex_wr = rd, RegWrite 1 unless noted:
  - 20 ADD Sign1; 21 ADD Sign0; 22 SUB Sign1; 23 SUB Sign0.
  - 24 AND; 25 OR; 26 XOR; 27 NOR.
  - 2A LT Sign1; 2B LT Sign0.
  - 00/02/03 SLL/SRL/SRA, SrcA 1, shamt = instr[10:6].
  - 04/06/07 SLLV/SRLV/SRAV, SrcA 0.
  - 08 jr: ADD, RegWrite 0, wr 0.
  - 09 jalr: ADD, wr = rd.
- I-type: SrcB 1, ex_wr = rt, RegWrite 1 unless noted:
  - 08 ADD Sign1 Ext1; 09 ADD Sign0 Ext1.
  - 0A LT Sign1 Ext1; 0B LT Sign0 Ext1.
  - 0C AND Ext0; 0D OR Ext0; 0E XOR Ext0.
  - 0F lui: SLL, SrcA 1, shamt = LUI_SHAMT, Ext0.
  - 23 lw: ADD Ext1.
  - 2B sw: ADD Ext1, RegWrite 0, wr 0.
- Branches: SrcB 0, RegWrite 0, wr 0:
  - 04 EQ; 05 NEQ; 06 LEZ; 07 GTZ.
  - 01 with rt=0: LTZ.
- Jumps: 02 j: ADD, RegWrite 0. 03 jal: ADD, RegWrite 1, wr 31.
- Any other op/funct, including op 01 with rt≠0:
  - ex_illegal 1, ALUFun NOP_FUN, RegWrite 0, wr 0.
  - ex_valid follows id_valid.
- Any computed destination of 0 forces ex_RegWrite 0.
- ex_rs = instr[25:21] and ex_rt = instr[20:16] for every loaded instruction.
- ex_imm = instr[15:0] for every loaded instruction.
- Reset asserted mid-stall or mid-flush wins immediately; the first edge after release loads normally.

Decomposition:
- Shared package `alu_defs`:
  - ALUFun localparams (FUN_ADD … FUN_GTZ).
  - Opcode and funct constants.
  - The bubble value; the EX-stage ALU uses the same constants.
- One natural sub-module, `alu_ctrl_decode`: purely combinational instr → control bundle.
- The top holds the ID/EX register with flush/stall priority.

Test Plan:
- Reset: reset=0 mid-run → all outputs 0 immediately without waiting for clk, ex_ALUFun=000000; release → next edge loads id_instr.
- sub $3,$1,$2 (0x00221822), valid → after 1 edge: ALUFun 000001, Sign 1, wr 3, RegWrite 1, SrcB 0.
- sltiu $5,$4,-1 (0x2C85FFFF) → ALUFun 110101, Sign 0, Ext 1, SrcB 1, wr 5.
- lui $7,0x1234 (0x3C071234) → ALUFun 100000, SrcA 1, shamt 16, imm 0x1234, Ext 0.
- bltz $2 (0x04400004) → ALUFun 111011, RegWrite 0. Same with rt=1 (0x04410004) → ex_illegal 1, RegWrite 0.
- Load add, then assert stall for 3 cycles with new instr → outputs hold. Then stall=1 and flush=1 together → bubble (valid 0, ALUFun 000000). Then jal (0x0C000010) → wr 31, RegWrite 1.

Source files
------------

// File: rtl/alu_ctrl_stage_pkg.sv
// alu_defs: constants shared by the ID-side ALU control stage and the EX-stage
// ALU. It holds the ALUFun codes, the MIPS opcode/funct values, the ID/EX
// control bundle, and a helper that builds the bubble value.
package alu_defs;

    // ALUFun codes. Bits [5:4] select the unit: arith, logic, shift or compare.
    localparam logic [5:0] FUN_ADD = 6'b000000;
    localparam logic [5:0] FUN_SUB = 6'b000001;
    localparam logic [5:0] FUN_AND = 6'b011000;
    localparam logic [5:0] FUN_OR  = 6'b011110;
    localparam logic [5:0] FUN_XOR = 6'b010110;
    localparam logic [5:0] FUN_NOR = 6'b010001;
    localparam logic [5:0] FUN_A   = 6'b011010;
    localparam logic [5:0] FUN_SLL = 6'b100000;
    localparam logic [5:0] FUN_SRL = 6'b100001;
    localparam logic [5:0] FUN_SRA = 6'b100011;
    localparam logic [5:0] FUN_EQ  = 6'b110011;
    localparam logic [5:0] FUN_NEQ = 6'b110001;
    localparam logic [5:0] FUN_LT  = 6'b110101;
    localparam logic [5:0] FUN_LEZ = 6'b111101;
    localparam logic [5:0] FUN_LTZ = 6'b111011;
    localparam logic [5:0] FUN_GTZ = 6'b111111;

    // Opcodes (instr[31:26]).
    localparam logic [5:0] OP_RTYPE = 6'h00, OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J     = 6'h02, OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06, OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08, OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A, OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C, OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E, OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23, OP_SW     = 6'h2B;

    // R-type funct codes (instr[5:0]).
    localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04, FN_SRLV = 6'h06, FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08, FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20, FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22, FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24, FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26, FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A, FN_SLTU = 6'h2B;

    // ID/EX control bundle.
    typedef struct packed {
        logic        valid;
        logic [5:0]  alufun;
        logic        sign;
        logic        srca;
        logic        srcb;
        logic        extop;
        logic [4:0]  shamt;
        logic [15:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wr;
        logic        regwrite;
        logic        illegal;
    } ctrl_t;

    // A bubble is all zeros except ALUFun, which carries the configured NOP.
    function automatic ctrl_t make_bubble(input logic [5:0] nop_fun);
        ctrl_t b;
        b        = '0;
        b.alufun = nop_fun;
        return b;
    endfunction

endpackage

// File: rtl/alu_ctrl_stage_if.sv
// ID -> ID/EX control interface.
// The master modport is the control stage: it takes the IF/ID instruction and
// the hazard controls, and it drives the registered EX-side control. The slave
// modport is the other side, meaning the IF/ID and hazard logic plus the EX
// consumer.
interface alu_ctrl_stage_if;
    logic [31:0] id_instr;
    logic        id_valid;
    logic        stall;
    logic        flush;

    logic        ex_valid;
    logic [5:0]  ex_ALUFun;
    logic        ex_Sign;
    logic        ex_ALUSrcA;
    logic        ex_ALUSrcB;
    logic        ex_ExtOp;
    logic [4:0]  ex_shamt;
    logic [15:0] ex_imm;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_wr;
    logic        ex_RegWrite;
    logic        ex_illegal;

    modport master (
        input  id_instr, id_valid, stall, flush,
        output ex_valid, ex_ALUFun, ex_Sign, ex_ALUSrcA, ex_ALUSrcB, ex_ExtOp,
               ex_shamt, ex_imm, ex_rs, ex_rt, ex_wr, ex_RegWrite, ex_illegal
    );

    modport slave (
        output id_instr, id_valid, stall, flush,
        input  ex_valid, ex_ALUFun, ex_Sign, ex_ALUSrcA, ex_ALUSrcB, ex_ExtOp,
               ex_shamt, ex_imm, ex_rs, ex_rt, ex_wr, ex_RegWrite, ex_illegal
    );
endinterface

// File: rtl/alu_ctrl_stage_decode.sv
// alu_ctrl_decode: a purely combinational decoder that turns a 32-bit MIPS
// instruction into the ID/EX control bundle.
//   instr : in  32  instruction
//   ctrl  : out     decoded bundle (valid = 1; the top substitutes a bubble when needed)
module alu_ctrl_decode
    import alu_defs::*;
#(
    parameter logic [5:0] NOP_FUN   = 6'b000000,
    parameter int         LUI_SHAMT = 16
) (
    input  logic [31:0] instr,
    output ctrl_t       ctrl
);
    logic [5:0] op, funct;
    logic [4:0] rs, rt, rd;
    logic       bad;
    logic       wr_rt;    // I-type ALU op: immediate operand, result goes to rt
    ctrl_t      c;

    assign op    = instr[31:26];
    assign funct = instr[5:0];
    assign rs    = instr[25:21];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];

    always_comb begin
        bad      = 1'b0;
        wr_rt    = 1'b0;
        c        = '0;
        c.valid  = 1'b1;
        c.alufun = FUN_ADD;
        c.rs     = rs;
        c.rt     = rt;
        c.imm    = instr[15:0];

        case (op)
            OP_RTYPE: begin
                c.wr       = rd;
                c.regwrite = 1'b1;
                case (funct)
                    FN_ADD:  c.sign = 1'b1;
                    FN_ADDU: ;
                    FN_SUB:  begin c.alufun = FUN_SUB; c.sign = 1'b1; end
                    FN_SUBU: c.alufun = FUN_SUB;
                    FN_AND:  c.alufun = FUN_AND;
                    FN_OR:   c.alufun = FUN_OR;
                    FN_XOR:  c.alufun = FUN_XOR;
                    FN_NOR:  c.alufun = FUN_NOR;
                    FN_SLT:  begin c.alufun = FUN_LT; c.sign = 1'b1; end
                    FN_SLTU: c.alufun = FUN_LT;
                    FN_SLL:  begin c.alufun = FUN_SLL; c.srca = 1'b1; c.shamt = instr[10:6]; end
                    FN_SRL:  begin c.alufun = FUN_SRL; c.srca = 1'b1; c.shamt = instr[10:6]; end
                    FN_SRA:  begin c.alufun = FUN_SRA; c.srca = 1'b1; c.shamt = instr[10:6]; end
                    FN_SLLV: c.alufun = FUN_SLL;
                    FN_SRLV: c.alufun = FUN_SRL;
                    FN_SRAV: c.alufun = FUN_SRA;
                    FN_JR:   begin c.regwrite = 1'b0; c.wr = 5'd0; end
                    FN_JALR: ;
                    default: bad = 1'b1;
                endcase
            end
            // Only bltz (rt == 0) is supported in the REGIMM group.
            OP_REGIMM: if (rt == 5'd0) c.alufun = FUN_LTZ; else bad = 1'b1;
            OP_BEQ:    c.alufun = FUN_EQ;
            OP_BNE:    c.alufun = FUN_NEQ;
            OP_BLEZ:   c.alufun = FUN_LEZ;
            OP_BGTZ:   c.alufun = FUN_GTZ;
            OP_J:      ;
            OP_JAL:    begin c.regwrite = 1'b1; c.wr = 5'd31; end
            OP_ADDI:   begin wr_rt = 1'b1; c.sign = 1'b1; c.extop = 1'b1; end
            OP_ADDIU:  begin wr_rt = 1'b1; c.extop = 1'b1; end
            OP_SLTI:   begin wr_rt = 1'b1; c.alufun = FUN_LT; c.sign = 1'b1; c.extop = 1'b1; end
            OP_SLTIU:  begin wr_rt = 1'b1; c.alufun = FUN_LT; c.extop = 1'b1; end
            OP_ANDI:   begin wr_rt = 1'b1; c.alufun = FUN_AND; end
            OP_ORI:    begin wr_rt = 1'b1; c.alufun = FUN_OR; end
            OP_XORI:   begin wr_rt = 1'b1; c.alufun = FUN_XOR; end
            // lui shifts the zero-extended imm16 left by a fixed amount.
            OP_LUI:    begin wr_rt = 1'b1; c.alufun = FUN_SLL; c.srca = 1'b1;
                             c.shamt = 5'(LUI_SHAMT); end
            OP_LW:     begin wr_rt = 1'b1; c.extop = 1'b1; end
            OP_SW:     begin c.srcb = 1'b1; c.extop = 1'b1; end
            default:   bad = 1'b1;
        endcase

        if (wr_rt) begin
            c.srcb     = 1'b1;
            c.wr       = rt;
            c.regwrite = 1'b1;
        end

        // Illegal: keep only the raw register and immediate fields.
        if (bad) begin
            c         = '0;
            c.valid   = 1'b1;
            c.illegal = 1'b1;
            c.alufun  = NOP_FUN;
            c.rs      = rs;
            c.rt      = rt;
            c.imm     = instr[15:0];
        end

        // $0 is never written.
        if (c.wr == 5'd0) c.regwrite = 1'b0;
    end

    assign ctrl = c;
endmodule

// File: rtl/alu_ctrl_stage.sv
// alu_ctrl_stage: the ID/EX pipeline register for the ALU control.
// It decodes id_instr and registers the result. Per edge, flush takes priority
// over stall, and stall takes priority over a load. A flush, and an invalid
// IF/ID slot, load a bubble.
//   clk   : in  rising-edge clock
//   reset : in  asynchronous active-low reset (loads a bubble)
//   bus   : alu_ctrl_stage_if.master, carrying the id_* and hazard inputs and the ex_* outputs
module alu_ctrl_stage
    import alu_defs::*;
#(
    parameter logic [5:0] NOP_FUN   = 6'b000000,
    parameter int         LUI_SHAMT = 16
) (
    input  logic                clk,
    input  logic                reset,
    alu_ctrl_stage_if.master    bus
);
    localparam ctrl_t BUBBLE = make_bubble(NOP_FUN);

    ctrl_t dec, q;

    alu_ctrl_decode #(.NOP_FUN(NOP_FUN), .LUI_SHAMT(LUI_SHAMT)) u_decode (
        .instr (bus.id_instr),
        .ctrl  (dec)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)             q <= BUBBLE;
        else if (bus.flush)     q <= BUBBLE;
        else if (bus.stall)     q <= q;
        else if (!bus.id_valid) q <= BUBBLE;
        else                    q <= dec;
    end

    assign bus.ex_valid    = q.valid;
    assign bus.ex_ALUFun   = q.alufun;
    assign bus.ex_Sign     = q.sign;
    assign bus.ex_ALUSrcA  = q.srca;
    assign bus.ex_ALUSrcB  = q.srcb;
    assign bus.ex_ExtOp    = q.extop;
    assign bus.ex_shamt    = q.shamt;
    assign bus.ex_imm      = q.imm;
    assign bus.ex_rs       = q.rs;
    assign bus.ex_rt       = q.rt;
    assign bus.ex_wr       = q.wr;
    assign bus.ex_RegWrite = q.regwrite;
    assign bus.ex_illegal  = q.illegal;
endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Self-checking bench for alu_ctrl_stage.
// The reference model is table driven: arrays indexed by funct and by opcode
// give each instruction's ALU function and attributes. A one-entry register
// model applies the flush > stall > load rule.
module tb_alu_ctrl_stage;

    typedef struct packed {
        logic        valid;
        logic [5:0]  fun;
        logic        sign, srca, srcb, ext;
        logic [4:0]  shamt;
        logic [15:0] imm;
        logic [4:0]  rs, rt, wr;
        logic        rw, ill;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;
    exp_t exp_q = '0;
    exp_t obs;

    // Reference tables. Destination kind: 0 = none, 1 = rt, 2 = rd, 3 = r31.
    logic [5:0] r_fun [64];  bit r_ok [64]; bit r_sign [64]; bit r_shift [64]; int r_dk [64];
    logic [5:0] i_fun [64];  bit i_ok [64]; bit i_sign [64]; bit i_ext [64];
    bit         i_srcb [64]; int i_dk [64];

    alu_ctrl_stage_if bus ();

    alu_ctrl_stage #(.NOP_FUN(6'b000000), .LUI_SHAMT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t observe();
        exp_t o;
        o = '{bus.ex_valid, bus.ex_ALUFun, bus.ex_Sign, bus.ex_ALUSrcA, bus.ex_ALUSrcB,
              bus.ex_ExtOp, bus.ex_shamt, bus.ex_imm, bus.ex_rs, bus.ex_rt, bus.ex_wr,
              bus.ex_RegWrite, bus.ex_illegal};
        return o;
    endfunction

    task automatic rset(input int f, input logic [5:0] fun, input bit s, input bit sh, input int dk);
        r_ok[f] = 1; r_fun[f] = fun; r_sign[f] = s; r_shift[f] = sh; r_dk[f] = dk;
    endtask

    task automatic iset(input int op, input logic [5:0] fun, input bit s, input bit e,
                        input bit b, input int dk);
        i_ok[op] = 1; i_fun[op] = fun; i_sign[op] = s; i_ext[op] = e; i_srcb[op] = b; i_dk[op] = dk;
    endtask

    task automatic init_tables();
        for (int k = 0; k < 64; k++) begin
            r_ok[k] = 0; r_fun[k] = 0; r_sign[k] = 0; r_shift[k] = 0; r_dk[k] = 0;
            i_ok[k] = 0; i_fun[k] = 0; i_sign[k] = 0; i_ext[k] = 0; i_srcb[k] = 0; i_dk[k] = 0;
        end
        rset('h20, 6'b000000, 1, 0, 2); rset('h21, 6'b000000, 0, 0, 2);
        rset('h22, 6'b000001, 1, 0, 2); rset('h23, 6'b000001, 0, 0, 2);
        rset('h24, 6'b011000, 0, 0, 2); rset('h25, 6'b011110, 0, 0, 2);
        rset('h26, 6'b010110, 0, 0, 2); rset('h27, 6'b010001, 0, 0, 2);
        rset('h2A, 6'b110101, 1, 0, 2); rset('h2B, 6'b110101, 0, 0, 2);
        rset('h00, 6'b100000, 0, 1, 2); rset('h02, 6'b100001, 0, 1, 2);
        rset('h03, 6'b100011, 0, 1, 2); rset('h04, 6'b100000, 0, 0, 2);
        rset('h06, 6'b100001, 0, 0, 2); rset('h07, 6'b100011, 0, 0, 2);
        rset('h08, 6'b000000, 0, 0, 0); rset('h09, 6'b000000, 0, 0, 2);
        iset('h08, 6'b000000, 1, 1, 1, 1); iset('h09, 6'b000000, 0, 1, 1, 1);
        iset('h0A, 6'b110101, 1, 1, 1, 1); iset('h0B, 6'b110101, 0, 1, 1, 1);
        iset('h0C, 6'b011000, 0, 0, 1, 1); iset('h0D, 6'b011110, 0, 0, 1, 1);
        iset('h0E, 6'b010110, 0, 0, 1, 1); iset('h0F, 6'b100000, 0, 0, 1, 1);
        iset('h23, 6'b000000, 0, 1, 1, 1); iset('h2B, 6'b000000, 0, 1, 1, 0);
        iset('h04, 6'b110011, 0, 0, 0, 0); iset('h05, 6'b110001, 0, 0, 0, 0);
        iset('h06, 6'b111101, 0, 0, 0, 0); iset('h07, 6'b111111, 0, 0, 0, 0);
        iset('h02, 6'b000000, 0, 0, 0, 0); iset('h03, 6'b000000, 0, 0, 0, 3);
    endtask

    // Expected ID/EX contents after loading this instruction.
    function automatic exp_t model(input logic [31:0] ins, input bit v);
        exp_t e;
        int   op, f, dk;
        e = '0;
        if (!v) return e;
        op = int'(ins[31:26]);
        f  = int'(ins[5:0]);
        e.valid = 1; e.rs = ins[25:21]; e.rt = ins[20:16]; e.imm = ins[15:0];
        dk = 0;
        if (op == 0 && r_ok[f]) begin
            e.fun = r_fun[f]; e.sign = r_sign[f]; dk = r_dk[f];
            if (r_shift[f]) begin e.srca = 1; e.shamt = ins[10:6]; end
        end else if (op == 1 && ins[20:16] == 0) begin
            e.fun = 6'b111011;
        end else if (op != 0 && op != 1 && i_ok[op]) begin
            e.fun = i_fun[op]; e.sign = i_sign[op]; e.ext = i_ext[op]; e.srcb = i_srcb[op];
            dk = i_dk[op];
            if (op == 'h0F) begin e.srca = 1; e.shamt = 5'd16; end
        end else begin
            e.ill = 1;
        end
        case (dk)
            1: e.wr = ins[20:16];
            2: e.wr = ins[15:11];
            3: e.wr = 5'd31;
            default: e.wr = 5'd0;
        endcase
        e.rw = (dk != 0) && (e.wr != 0);
        return e;
    endfunction

    // Drive inputs, take one edge, update the model, and settle for sampling.
    task automatic cycle(input logic [31:0] ins, input bit v, input bit s, input bit f);
        bus.id_instr = ins; bus.id_valid = v; bus.stall = s; bus.flush = f;
        @(posedge clk);
        if (f)      exp_q = '0;
        else if (!s) exp_q = model(ins, v);
        #1;
    endtask

    task automatic test_reset();
        bus.id_instr = 32'h00221822; bus.id_valid = 1; bus.stall = 0; bus.flush = 0;
        #12;
        obs = observe(); n_total++;
        if (obs !== exp_t'('0)) $display("FAIL reset_initial got %h want 0", obs);
        else n_pass++;
        @(negedge clk); reset = 1'b1;
        cycle(32'h00221822, 1, 0, 0);
        // Mid-run async reset: the outputs clear with no clock edge.
        #2 reset = 1'b0; #1;
        obs = observe(); n_total++;
        if (obs !== exp_t'('0)) $display("FAIL reset_async got %h want 0", obs);
        else n_pass++;
        exp_q = '0;
        @(negedge clk); reset = 1'b1;
        cycle(32'h00221822, 1, 0, 0);
        obs = observe(); n_total++;
        if (obs !== exp_q) $display("FAIL reset_release_load got %h want %h", obs, exp_q);
        else n_pass++;
    endtask

    task automatic test_directed();
        cycle(32'h00221822, 1, 0, 0);  // sub $3,$1,$2
        obs = observe(); n_total++;
        if ({obs.fun, obs.sign, obs.wr, obs.rw, obs.srcb} !== {6'b000001, 1'b1, 5'd3, 1'b1, 1'b0})
            $display("FAIL sub got %h", obs);
        else n_pass++;
        cycle(32'h2C85FFFF, 1, 0, 0);  // sltiu $5,$4,-1
        obs = observe(); n_total++;
        if ({obs.fun, obs.sign, obs.ext, obs.srcb, obs.wr} !== {6'b110101, 1'b0, 1'b1, 1'b1, 5'd5})
            $display("FAIL sltiu got %h", obs);
        else n_pass++;
        cycle(32'h3C071234, 1, 0, 0);  // lui $7,0x1234
        obs = observe(); n_total++;
        if ({obs.fun, obs.srca, obs.shamt, obs.imm, obs.ext} !== {6'b100000, 1'b1, 5'd16, 16'h1234, 1'b0})
            $display("FAIL lui got %h", obs);
        else n_pass++;
        cycle(32'h04400004, 1, 0, 0);  // bltz $2
        obs = observe(); n_total++;
        if ({obs.fun, obs.rw, obs.ill} !== {6'b111011, 1'b0, 1'b0}) $display("FAIL bltz got %h", obs);
        else n_pass++;
        cycle(32'h04410004, 1, 0, 0);  // REGIMM with rt=1 is illegal
        obs = observe(); n_total++;
        if ({obs.ill, obs.rw, obs.fun, obs.valid} !== {1'b1, 1'b0, 6'b000000, 1'b1})
            $display("FAIL regimm_rt1 got %h", obs);
        else n_pass++;
        cycle(32'h00221822, 0, 0, 0);  // id_valid=0 loads a bubble
        obs = observe(); n_total++;
        if (obs !== exp_t'('0)) $display("FAIL invalid_bubble got %h want 0", obs);
        else n_pass++;
        cycle(32'h00201020, 1, 0, 0);  // add $2,$1,$0
        obs = observe(); n_total++;
        if (obs !== exp_q) $display("FAIL add got %h want %h", obs, exp_q);
        else n_pass++;
        cycle(32'h20000005, 1, 0, 0);  // addi $0,$0,5: destination $0 means no write
        obs = observe(); n_total++;
        if ({obs.rw, obs.wr} !== {1'b0, 5'd0}) $display("FAIL dest_zero got %h", obs);
        else n_pass++;
    endtask

    task automatic test_stall_flush();
        exp_t held;
        cycle(32'h00221820, 1, 0, 0);  // add $3,$1,$2
        held = observe();
        for (int k = 0; k < 3; k++) begin
            cycle(32'h3C071234, 1, 1, 0);
            obs = observe(); n_total++;
            if (obs !== held || obs !== exp_q) $display("FAIL stall_hold%0d got %h want %h", k, obs, held);
            else n_pass++;
        end
        cycle(32'h3C071234, 1, 1, 1);
        obs = observe(); n_total++;
        if ({obs.valid, obs.fun, obs.rw, obs.wr} !== {1'b0, 6'b000000, 1'b0, 5'd0} || obs !== exp_q)
            $display("FAIL stall_flush_bubble got %h", obs);
        else n_pass++;
        cycle(32'h0C000010, 1, 0, 0);  // jal
        obs = observe(); n_total++;
        if ({obs.wr, obs.rw, obs.fun} !== {5'd31, 1'b1, 6'b000000}) $display("FAIL jal got %h", obs);
        else n_pass++;
    endtask

    task automatic test_reset_mid_stall();
        cycle(32'h00221822, 1, 0, 0);
        bus.stall = 1; bus.flush = 1;
        #2 reset = 1'b0; #1;
        obs = observe(); n_total++;
        if (obs !== exp_t'('0)) $display("FAIL reset_mid_stall got %h want 0", obs);
        else n_pass++;
        exp_q = '0;
        @(negedge clk); reset = 1'b1;
        cycle(32'h0C000010, 1, 0, 0);
        obs = observe(); n_total++;
        if (obs !== exp_q) $display("FAIL after_reset_load got %h want %h", obs, exp_q);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [5:0]  ops [21] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05,
                                  6'h06, 6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
                                  6'h0E, 6'h0F, 6'h23, 6'h2B};
        logic [31:0] ins;
        bit v, s, f;
        int errs;
        errs = 0;
        for (int k = 0; k < 400; k++) begin
            ins = $urandom;
            if ($urandom_range(0, 3) != 0) ins[31:26] = ops[$urandom_range(0, 20)];
            if (ins[31:26] == 6'h01 && $urandom_range(0, 1) == 1) ins[20:16] = 5'd0;
            v = ($urandom_range(0, 9) != 0);
            s = ($urandom_range(0, 4) == 0);
            f = ($urandom_range(0, 7) == 0);
            cycle(ins, v, s, f);
            obs = observe(); n_total++;
            if (obs !== exp_q) begin
                errs++;
                if (errs <= 10)
                    $display("FAIL random%0d instr %h v%0d s%0d f%0d got %h want %h",
                             k, ins, v, s, f, obs, exp_q);
            end else n_pass++;
        end
    endtask

    initial begin
        init_tables();
        test_reset();
        test_directed();
        test_stall_flush();
        test_reset_mid_stall();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
